// File: rtl/pc_stack_pkg.sv
// Shared types and the priority decoder for the program counter with return stack.
package pc_pkg;

    // Action selected for the current cycle, after priority resolution.
    typedef enum logic [2:0] {
        PC_INC,
        PC_HOLD,
        PC_JMP,
        PC_CALL,
        PC_RET,
        PC_CALL_OVF,
        PC_RET_UNF
    } pc_op_t;

    // Reset is handled by the registers themselves.
    // The order below is stall, jump, call, return, then increment.
    // A call into a full stack or a return from an empty stack becomes an
    // error op that only increments.
    function automatic pc_op_t pc_decode(
        input logic en,
        input logic jmp,
        input logic call,
        input logic ret,
        input logic full,
        input logic empty
    );
        pc_op_t op;
        op = PC_INC;
        if (!en) begin
            op = PC_HOLD;
        end else if (jmp) begin
            op = PC_JMP;
        end else if (call) begin
            op = full ? PC_CALL_OVF : PC_CALL;
        end else if (ret) begin
            op = empty ? PC_RET_UNF : PC_RET;
        end
        return op;
    endfunction

endpackage

// File: rtl/pc_stack_ret_stack.sv
// Parametrised LIFO of return addresses.
// Pushing into a full stack and popping an empty one are ignored.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           full,
    output logic                           empty
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    top_ptr;

    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
    assign top_ptr = depth - 1'b1;
    assign top     = empty ? '0 : mem[top_ptr[IW-1:0]];

    // Occupancy counter: a push has precedence if both strobes are ever raised together.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
        end else if (push && !full) begin
            depth <= depth + 1'b1;
        end else if (pop && !empty) begin
            depth <= depth - 1'b1;
        end
    end

    // Entry storage is deliberately left uncleared on reset; only the depth matters.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[depth[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with integrated return-address stack, stall and sticky stack-error flags.
module pc_stack
    import pc_pkg::*;
#(
    parameter int                         INSTR_ADDR_SIZE = 6,
    parameter int                         STACK_DEPTH     = 4,
    parameter logic [INSTR_ADDR_SIZE-1:0] RESET_ADDR      = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic                               jmp,
    input  logic                               call,
    input  logic                               ret,
    input  logic [INSTR_ADDR_SIZE-1:0]         tgt_addr,
    input  logic                               err_clr,
    output logic [INSTR_ADDR_SIZE-1:0]         instr_addr,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               ovf_err,
    output logic                               unf_err
);

    pc_op_t                     op;
    logic [INSTR_ADDR_SIZE-1:0] seq_addr;
    logic [INSTR_ADDR_SIZE-1:0] stack_top;
    logic                       do_push;
    logic                       do_pop;

    // The sequential address wraps naturally at the register width, so a return
    // address taken at the maximum address becomes zero.
    assign seq_addr = instr_addr + 1'b1;
    assign op       = pc_decode(en, jmp, call, ret, stack_full, stack_empty);
    assign do_push  = (op == PC_CALL);
    assign do_pop   = (op == PC_RET);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (INSTR_ADDR_SIZE)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .din   (seq_addr),
        .top   (stack_top),
        .depth (stack_depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Address register: next address chosen by the decoded op; errors fall through to increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_addr <= RESET_ADDR;
        end else begin
            case (op)
                PC_HOLD:     instr_addr <= instr_addr;
                PC_JMP:      instr_addr <= tgt_addr;
                PC_CALL:     instr_addr <= tgt_addr;
                PC_RET:      instr_addr <= stack_top;
                PC_CALL_OVF: instr_addr <= seq_addr;
                PC_RET_UNF:  instr_addr <= seq_addr;
                default:     instr_addr <= seq_addr;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (op == PC_CALL_OVF) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (op == PC_RET_UNF) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end

endmodule
